// File: rtl/uart_reg_poller.sv
// rtl/uart_reg_poller.sv - polls a UART register bus and bridges its TX/RX FIFOs to valid/ready byte streams
module uart_reg_poller #(
    parameter logic [3:0] P_STAT_ADDR   = 4'h2,
    parameter logic [3:0] P_TXD_ADDR    = 4'h3,
    parameter logic [3:0] P_RXD_ADDR    = 4'h4,
    parameter int unsigned P_TXFULL_BIT  = 0,
    parameter int unsigned P_RXEMPTY_BIT = 1,
    parameter logic [7:0] P_TMO         = 8'd255
) (
    input  logic       app_clk,
    input  logic       app_rst,
    input  logic       cfg_en,
    output logic       reg_cs,
    output logic       reg_wr,
    output logic [3:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_be,
    input  logic [7:0] reg_rdata,
    input  logic       reg_ack,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       bus_err
);

    typedef enum logic [1:0] {IDLE, STAT, RXRD, TXWR} state_t;

    localparam logic [2:0] TXF_IDX = 3'(P_TXFULL_BIT);
    localparam logic [2:0] RXE_IDX = 3'(P_RXEMPTY_BIT);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic       stat_vld;
    logic       txfull;
    logic       rxempty;
    logic       pref_tx;
    logic       tx_full;
    logic [7:0] tx_hold;

    logic busy;
    logic timeout;
    logic done;
    logic rx_elig;
    logic tx_elig;

    // A transaction ends on ack; the timeout only fires when no ack arrives in that cycle.
    assign busy    = (state != IDLE);
    assign timeout = busy && !reg_ack && (wait_cnt == P_TMO);
    assign done    = busy && (reg_ack || timeout);
    assign rx_elig = !rxempty && !rx_valid;
    assign tx_elig = !txfull && tx_full;
    assign tx_ready = !tx_full;

    // State register.
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state choice and bus outputs; bus outputs depend only on state so they stay stable for the whole transaction.
    always_comb begin
        state_nxt = state;
        reg_cs    = 1'b0;
        reg_be    = 1'b0;
        reg_wr    = 1'b0;
        reg_addr  = 4'h0;
        reg_wdata = 8'h00;
        case (state)
            IDLE: begin
                if (cfg_en) begin
                    if (!stat_vld) begin
                        state_nxt = STAT;
                    end else if (rx_elig && tx_elig) begin
                        state_nxt = pref_tx ? TXWR : RXRD;
                    end else if (rx_elig) begin
                        state_nxt = RXRD;
                    end else if (tx_elig) begin
                        state_nxt = TXWR;
                    end else begin
                        state_nxt = STAT;
                    end
                end
            end
            STAT: begin
                reg_cs   = 1'b1;
                reg_be   = 1'b1;
                reg_addr = P_STAT_ADDR;
                if (done) state_nxt = IDLE;
            end
            RXRD: begin
                reg_cs   = 1'b1;
                reg_be   = 1'b1;
                reg_addr = P_RXD_ADDR;
                if (done) state_nxt = IDLE;
            end
            TXWR: begin
                reg_cs    = 1'b1;
                reg_be    = 1'b1;
                reg_wr    = 1'b1;
                reg_addr  = P_TXD_ADDR;
                reg_wdata = tx_hold;
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ack wait counter: zero outside transactions, counts cycles spent waiting inside one.
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            wait_cnt <= 8'd0;
        end else if (!busy || done) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Cached UART status; any data transaction or timeout invalidates it so the next step re-polls.
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            stat_vld <= 1'b0;
            txfull   <= 1'b0;
            rxempty  <= 1'b1;
        end else if (state == STAT && reg_ack) begin
            stat_vld <= 1'b1;
            txfull   <= reg_rdata[TXF_IDX];
            rxempty  <= reg_rdata[RXE_IDX];
        end else if (timeout || ((state == RXRD || state == TXWR) && reg_ack)) begin
            stat_vld <= 1'b0;
        end
    end

    // Round-robin preference: after a successful data transfer, favour the other direction.
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            pref_tx <= 1'b0;
        end else if (state == RXRD && reg_ack) begin
            pref_tx <= 1'b1;
        end else if (state == TXWR && reg_ack) begin
            pref_tx <= 1'b0;
        end
    end

    // RX output register: filled by an RX data read, drained by the consumer handshake.
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
        end else if (state == RXRD && reg_ack) begin
            rx_valid <= 1'b1;
            rx_data  <= reg_rdata;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    // TX holding register: filled by the producer handshake, emptied only by an acked write so a timeout retries the byte.
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            tx_full <= 1'b0;
            tx_hold <= 8'h00;
        end else if (state == TXWR && reg_ack) begin
            tx_full <= 1'b0;
        end else if (tx_valid && !tx_full) begin
            tx_full <= 1'b1;
            tx_hold <= tx_data;
        end
    end

    // Timeout pulse, visible in the first idle cycle after the abandoned transaction.
    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            bus_err <= 1'b0;
        end else begin
            bus_err <= timeout;
        end
    end

endmodule

// File: tb/tb_uart_reg_poller.sv
// tb/tb_uart_reg_poller.sv - directed and randomized bench for uart_reg_poller against a UART register model
module tb_uart_reg_poller;

    localparam logic [3:0] STAT_A = 4'h2;
    localparam logic [3:0] TXD_A  = 4'h3;
    localparam logic [3:0] RXD_A  = 4'h4;
    localparam int         TMO    = 4;
    localparam int         TXCAP  = 4;

    logic       app_clk = 1'b0;
    logic       app_rst;
    logic       cfg_en;
    logic       reg_cs;
    logic       reg_wr;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_be;
    logic [7:0] reg_rdata;
    logic       reg_ack;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       bus_err;

    uart_reg_poller #(.P_TMO(8'd4)) dut (
        .app_clk(app_clk), .app_rst(app_rst), .cfg_en(cfg_en),
        .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_be(reg_be), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .bus_err(bus_err)
    );

    always #5 app_clk = ~app_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // current transaction as seen on the bus
    int         k = -1;
    int         cur_dly = 0;
    logic [3:0] t_addr = 4'h0;
    logic       t_wr = 1'b0;
    logic [7:0] t_wdata = 8'h00;
    bit         done_prev = 0;
    bit         tmo_prev = 0;
    bit         cfg_prev = 0;

    // knowledge the poller may legitimately have about the UART
    bit stat_valid = 0;
    bit seen_rxempty = 1;
    bit seen_txfull = 0;
    int last_stat_ack = -100;

    // stimulus knobs
    int dly_stat = 1, dly_rxd = 1, dly_txd = 1;
    bit rand_dly = 0, junk_ack = 0, rx_arrive = 0, cfg_rand = 0, chk_lat = 0;
    int stat_force = -1;
    int prod_mode = 0, cons_mode = 0;

    // UART model and scoreboards
    logic [7:0] rxq[$];
    logic [7:0] rxexp[$];
    logic [7:0] txexp[$];
    logic [7:0] txall[$];
    logic [3:0] log_addr[$];
    logic [7:0] log_wdata[$];
    int txcap_cnt = 0;
    int berr_cnt = 0, tmo_len = 0;
    int tx_offered = 0, rx_reads = 0, rx_taken = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int count_addr(input logic [3:0] a);
        int n;
        n = 0;
        foreach (log_addr[i]) if (log_addr[i] == a) n++;
        return n;
    endfunction

    task automatic start_txn();
        k = 0;
        t_addr = reg_addr;
        t_wr = reg_wr;
        t_wdata = reg_wdata;
        log_addr.push_back(reg_addr);
        log_wdata.push_back(reg_wdata);
        chk("start_needs_cfg_en", cfg_prev, 1'b1);
        chk("wr_matches_addr", reg_wr, reg_addr == TXD_A);
        if (!stat_valid) chk("stat_first", reg_addr, STAT_A);
        if (reg_addr == RXD_A) begin
            chk("rx_eligible", stat_valid && !seen_rxempty && rxexp.size() == 0, 1'b1);
            if (chk_lat) chk("stat_to_rxrd_latency", cyc - last_stat_ack, 2);
        end else if (reg_addr == TXD_A) begin
            chk("tx_eligible", stat_valid && !seen_txfull && txexp.size() > 0, 1'b1);
            if (txexp.size() > 0) chk("tx_wdata_is_head", reg_wdata, txexp[0]);
        end else begin
            chk("addr_is_stat", reg_addr, STAT_A);
        end
        if (rand_dly) cur_dly = $urandom_range(0, TMO);
        else if (reg_addr == STAT_A) cur_dly = dly_stat;
        else if (reg_addr == RXD_A) cur_dly = dly_rxd;
        else cur_dly = dly_txd;
    endtask

    task automatic monitor();
        chk("bus_err", bus_err, tmo_prev);
        chk("be_eq_cs", reg_be, reg_cs);
        if (bus_err === 1'b1) berr_cnt++;
        if (done_prev) begin
            chk("gap_after_done", reg_cs, 1'b0);
            k = -1;
        end else if (k >= 0) begin
            chk("cs_held", reg_cs, 1'b1);
            if (reg_cs === 1'b1) begin
                chk("addr_stable", reg_addr, t_addr);
                chk("wr_stable", reg_wr, t_wr);
                chk("wdata_stable", reg_wdata, t_wdata);
                k++;
            end else begin
                k = -1;
            end
        end
        if (reg_cs === 1'b1 && k < 0) start_txn();
    endtask

    task automatic drive();
        reg_ack = 1'b0;
        reg_rdata = 8'($urandom);
        if (reg_cs === 1'b1 && k >= 0) begin
            if (cur_dly >= 0 && k == cur_dly) begin
                reg_ack = 1'b1;
                if (t_addr == STAT_A)
                    reg_rdata = (stat_force >= 0) ? stat_force[7:0]
                                                  : {6'd0, rxq.size() == 0, txcap_cnt >= TXCAP};
                else if (t_addr == RXD_A)
                    reg_rdata = (rxq.size() > 0) ? rxq.pop_front() : 8'($urandom);
            end
        end else if (junk_ack) begin
            reg_ack = 1'($urandom_range(0, 1));
        end
        if (stat_force < 0 && txcap_cnt > 0 && $urandom_range(0, 3) == 0) txcap_cnt--;
        if (rx_arrive && rxq.size() < 4 && $urandom_range(0, 7) == 0) rxq.push_back(8'($urandom));
        if (prod_mode == 1) begin
            tx_valid = 1'b1;
            tx_data = 8'($urandom);
        end else if (prod_mode == 2) begin
            tx_valid = 1'($urandom_range(0, 1));
            tx_data = 8'($urandom);
        end
        if (cons_mode == 1) rx_ready = 1'($urandom_range(0, 1));
        if (cfg_rand) cfg_en = ($urandom_range(0, 7) != 0);
    endtask

    // record what the coming edge does, using the final input values of this cycle
    task automatic commit();
        if (app_rst === 1'b1) begin
            txexp.delete();
            rxexp.delete();
            stat_valid = 0;
            k = -1;
            done_prev = 0;
            tmo_prev = 0;
            cfg_prev = cfg_en;
            return;
        end
        tmo_prev  = (reg_cs === 1'b1 && k >= 0 && reg_ack !== 1'b1 && k == TMO);
        done_prev = (reg_cs === 1'b1 && k >= 0 && (reg_ack === 1'b1 || k == TMO));
        if (reg_cs === 1'b1 && k >= 0 && reg_ack === 1'b1) begin
            if (t_addr == STAT_A) begin
                stat_valid = 1;
                seen_txfull = reg_rdata[0];
                seen_rxempty = reg_rdata[1];
                last_stat_ack = cyc;
            end else if (t_addr == RXD_A) begin
                rxexp.push_back(reg_rdata);
                rx_reads++;
                stat_valid = 0;
            end else begin
                chk("tx_pending_count", txexp.size(), 1);
                if (txexp.size() > 0) chk("tx_write_byte", t_wdata, txexp.pop_front());
                txall.push_back(t_wdata);
                txcap_cnt++;
                stat_valid = 0;
            end
        end
        if (tmo_prev) begin
            stat_valid = 0;
            tmo_len = k + 1;
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            txexp.push_back(tx_data);
            tx_offered++;
        end
        if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
            rx_taken++;
            if (rxexp.size() > 0) chk("rx_byte", rx_data, rxexp.pop_front());
            else chk("rx_spurious", rx_valid, 1'b0);
        end
        cfg_prev = cfg_en;
    endtask

    task automatic tick();
        commit();
        @(posedge app_clk);
        #1;
        cyc++;
        monitor();
        drive();
    endtask

    task automatic do_reset();
        app_rst = 1'b1;
        cfg_en = 1'b0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        prod_mode = 0; cons_mode = 0;
        junk_ack = 0; rx_arrive = 0; cfg_rand = 0; rand_dly = 0; chk_lat = 0;
        stat_force = -1;
        dly_stat = 1; dly_rxd = 1; dly_txd = 1;
        tick();
        tick();
        app_rst = 1'b0;
        rxq.delete(); txall.delete(); log_addr.delete(); log_wdata.delete();
        txcap_cnt = 0; berr_cnt = 0; tmo_len = 0;
        tx_offered = 0; rx_reads = 0; rx_taken = 0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_cs"}, reg_cs, 1'b0);
        chk({pfx, "_wr"}, reg_wr, 1'b0);
        chk({pfx, "_addr"}, reg_addr, 4'h0);
        chk({pfx, "_wdata"}, reg_wdata, 8'h00);
        chk({pfx, "_be"}, reg_be, 1'b0);
        chk({pfx, "_tx_ready"}, tx_ready, 1'b1);
        chk({pfx, "_rx_valid"}, rx_valid, 1'b0);
        chk({pfx, "_rx_data"}, rx_data, 8'h00);
        chk({pfx, "_bus_err"}, bus_err, 1'b0);
    endtask

    initial begin
        int n;
        int c0;
        app_rst = 1'b1; cfg_en = 1'b0; reg_ack = 1'b0; reg_rdata = 8'h00;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;

        // reset state
        do_reset();
        chk_reset_outputs("reset");

        // status read then RX read of 8'hA5, acks after 2 cycles
        do_reset();
        dly_stat = 2; dly_rxd = 2;
        rxq.push_back(8'hA5);
        cfg_en = 1'b1;
        tick();
        chk("stat_issued_next_cycle", reg_cs, 1'b1);
        chk("stat_addr", reg_addr, STAT_A);
        for (int i = 0; i < 40 && rx_valid !== 1'b1; i++) tick();
        chk("rx_valid_set", rx_valid, 1'b1);
        chk("rx_data_a5", rx_data, 8'hA5);
        chk("rd_txn_count", log_addr.size(), 2);
        chk("rd_txn0_stat", log_addr[0], STAT_A);
        chk("rd_txn1_rxrd", log_addr[1], RXD_A);
        rx_ready = 1'b1;
        tick();
        chk("rx_valid_cleared", rx_valid, 1'b0);

        // best-case latency with immediate acks
        do_reset();
        dly_stat = 0; dly_rxd = 0;
        rxq.push_back(8'h5E);
        chk_lat = 1;
        cfg_en = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 40 && rx_valid !== 1'b1; i++) tick();
        chk("best_case_total", cyc - c0, 4);
        chk("best_case_rx_data", rx_data, 8'h5E);
        chk_lat = 0;

        // single TX write of 8'h3C with status 8'h02
        do_reset();
        tx_valid = 1'b1; tx_data = 8'h3C;
        chk("tx_ready_empty", tx_ready, 1'b1);
        tick();
        tx_valid = 1'b0;
        chk("tx_ready_low_after_load", tx_ready, 1'b0);
        cfg_en = 1'b1;
        for (int i = 0; i < 40 && tx_ready !== 1'b1; i++) tick();
        chk("tx_ready_after_write", tx_ready, 1'b1);
        chk("tx_write_count", count_addr(TXD_A), 1);
        chk("tx_written_byte", txall[0], 8'h3C);

        // fairness with both directions always eligible
        do_reset();
        stat_force = 0; rand_dly = 1; prod_mode = 1; rx_ready = 1'b1;
        tx_valid = 1'b1; tx_data = 8'h11;
        cfg_en = 1'b1;
        repeat (300) tick();
        n = 0;
        foreach (log_addr[i]) begin
            if (log_addr[i] != STAT_A && n < 12) begin
                chk("fair_order", log_addr[i], (n % 2 == 0) ? RXD_A : TXD_A);
                n++;
            end
        end
        chk("fair_enough_txns", n >= 12, 1'b1);

        // RX backpressure: only status polls while the RX byte is unconsumed
        do_reset();
        stat_force = 0;
        cfg_en = 1'b1;
        repeat (60) tick();
        chk("bp_single_rxrd", count_addr(RXD_A), 1);
        chk("bp_stat_polls", count_addr(STAT_A) >= 5, 1'b1);
        rx_ready = 1'b1;
        for (int i = 0; i < 40 && count_addr(RXD_A) < 2; i++) tick();
        chk("bp_second_rxrd", count_addr(RXD_A), 2);

        // TX write timeout, then retry acked exactly at the timeout count
        do_reset();
        dly_txd = -1;
        tx_valid = 1'b1; tx_data = 8'h5A;
        tick();
        tx_valid = 1'b0;
        cfg_en = 1'b1;
        for (int i = 0; i < 60 && berr_cnt == 0; i++) tick();
        chk("tmo_bus_err_once", berr_cnt, 1);
        chk("tmo_cs_cycles", tmo_len, 5);
        chk("tmo_cs_low", reg_cs, 1'b0);
        chk("tmo_byte_retained", tx_ready, 1'b0);
        dly_txd = TMO;
        for (int i = 0; i < 60 && tx_ready !== 1'b1; i++) tick();
        chk("retry_done", tx_ready, 1'b1);
        chk("retry_no_bus_err", berr_cnt, 1);
        chk("retry_write_count", count_addr(TXD_A), 2);
        n = 0;
        foreach (log_addr[i]) begin
            if (log_addr[i] == TXD_A) begin
                chk("retry_same_byte", log_wdata[i], 8'h5A);
                n++;
            end
        end
        chk("retry_delivered", txall.size(), 1);

        // reset in the middle of an RX read, with a TX byte held
        do_reset();
        dly_stat = 0; dly_rxd = -1;
        rxq.push_back(8'h77);
        tx_valid = 1'b1; tx_data = 8'hC3;
        tick();
        tx_valid = 1'b0;
        cfg_en = 1'b1;
        for (int i = 0; i < 40 && !(reg_cs === 1'b1 && reg_addr === RXD_A); i++) tick();
        chk("midrx_reached", reg_cs === 1'b1 && reg_addr === RXD_A, 1'b1);
        app_rst = 1'b1;
        tick();
        chk_reset_outputs("midrx");
        app_rst = 1'b0;
        cfg_en = 1'b0;

        // randomized traffic against the UART model
        do_reset();
        rand_dly = 1; junk_ack = 1; rx_arrive = 1; prod_mode = 2; cons_mode = 1; cfg_rand = 1;
        repeat (3000) tick();
        prod_mode = 0; tx_valid = 1'b0; cons_mode = 0; rx_ready = 1'b1;
        cfg_rand = 0; cfg_en = 1'b1; rx_arrive = 0; junk_ack = 0;
        for (int i = 0; i < 600 && !(txexp.size() == 0 && rxexp.size() == 0 && rxq.size() == 0
                                     && tx_ready === 1'b1 && rx_valid !== 1'b1); i++) tick();
        chk("rand_drained", txexp.size() == 0 && rxexp.size() == 0 && rxq.size() == 0, 1'b1);
        chk("rand_tx_all_written", txall.size(), tx_offered);
        chk("rand_rx_all_taken", rx_taken, rx_reads);
        chk("rand_no_bus_err", berr_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
